// File: rtl/alu_pipe.sv
// Pipelined ALU: one beat per cycle, result appears LATENCY cycles after acceptance.
// The whole pipe stalls together when the output is valid and not taken.
module alu_pipe #(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid,
  output logic                  action_ready,
  input  logic [DATA_WIDTH-1:0] operand_1_in,
  input  logic [DATA_WIDTH-1:0] operand_2_in,
  output logic [DATA_WIDTH-1:0] container_out,
  output logic                  container_out_valid,
  input  logic                  container_out_ready,
  output logic                  overflow_out
);

  if (LATENCY < 1 || LATENCY > 8 || STAGE_ID < 0) begin : g_bad_param
    $error("alu_pipe: LATENCY must be 1..8 and STAGE_ID non-negative");
  end

  localparam logic [3:0] OP_ADD    = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_ADDS   = 4'b1001;
  localparam logic [3:0] OP_SUBS   = 4'b1010;
  localparam logic [3:0] OP_AND    = 4'b0100;
  localparam logic [3:0] OP_OR     = 4'b0101;
  localparam logic [3:0] OP_XOR    = 4'b0111;
  localparam logic [3:0] OP_GE     = 4'b0110;
  localparam logic [3:0] OP_EQ     = 4'b1000;
  localparam logic [3:0] OP_SHL    = 4'b1011;
  localparam logic [3:0] OP_SHR    = 4'b1100;
  localparam logic [3:0] OP_PASS_B = 4'b1110;

  logic [3:0]            opcode;
  logic [DATA_WIDTH:0]   sum_ext;
  logic [DATA_WIDTH-1:0] diff;
  logic                  borrow;
  logic [5:0]            shamt;
  logic                  shift_oob;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_flag;
  logic                  advance;
  logic                  unused_action_bits;

  assign opcode             = action_in[ACTION_LEN-1 -: 4];
  assign unused_action_bits = ^action_in[ACTION_LEN-5:0];
  assign sum_ext            = {1'b0, operand_1_in} + {1'b0, operand_2_in};
  assign diff               = operand_1_in - operand_2_in;
  assign borrow             = operand_1_in < operand_2_in;
  assign shamt              = operand_2_in[5:0];
  assign shift_oob          = int'(shamt) >= DATA_WIDTH;

  always_comb begin
    alu_res  = operand_1_in;
    alu_flag = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res  = sum_ext[DATA_WIDTH-1:0];
        alu_flag = sum_ext[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_res  = diff;
        alu_flag = borrow;
      end
      OP_ADDS: begin
        alu_res  = sum_ext[DATA_WIDTH] ? '1 : sum_ext[DATA_WIDTH-1:0];
        alu_flag = sum_ext[DATA_WIDTH];
      end
      OP_SUBS: begin
        alu_res  = borrow ? '0 : diff;
        alu_flag = borrow;
      end
      OP_AND:    alu_res = operand_1_in & operand_2_in;
      OP_OR:     alu_res = operand_1_in | operand_2_in;
      OP_XOR:    alu_res = operand_1_in ^ operand_2_in;
      OP_GE:     alu_res = {{(DATA_WIDTH-1){1'b0}}, operand_1_in >= operand_2_in};
      OP_EQ:     alu_res = {{(DATA_WIDTH-1){1'b0}}, operand_1_in == operand_2_in};
      OP_SHL:    alu_res = shift_oob ? '0 : operand_1_in << shamt;
      OP_SHR:    alu_res = shift_oob ? '0 : operand_1_in >> shamt;
      OP_PASS_B: alu_res = operand_2_in;
      default:   alu_res = operand_1_in;
    endcase
  end

  logic                  vld_q  [LATENCY];
  logic [DATA_WIDTH-1:0] res_q  [LATENCY];
  logic                  flag_q [LATENCY];

  assign advance      = !container_out_valid || container_out_ready;
  assign action_ready = advance;

  // Payload only moves behind a valid bit, so bubbles leave the output register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        res_q[i]  <= '0;
        flag_q[i] <= 1'b0;
      end
    end else if (advance) begin
      vld_q[0] <= action_valid;
      if (action_valid) begin
        res_q[0]  <= alu_res;
        flag_q[0] <= alu_flag;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          res_q[i]  <= res_q[i-1];
          flag_q[i] <= flag_q[i-1];
        end
      end
    end
  end

  assign container_out       = res_q[LATENCY-1];
  assign container_out_valid = vld_q[LATENCY-1];
  assign overflow_out        = flag_q[LATENCY-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at default parameters (DATA_WIDTH=48, LATENCY=3).
module tb_alu_pipe;

  localparam int AW = 25;
  localparam int DW = 48;
  localparam int NV = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] action_in;
  logic          action_valid;
  logic          action_ready;
  logic [DW-1:0] operand_1_in;
  logic [DW-1:0] operand_2_in;
  logic [DW-1:0] container_out;
  logic          container_out_valid;
  logic          container_out_ready;
  logic          overflow_out;

  int n_cmp = 0;
  int n_bad = 0;

  alu_pipe dut (
    .clk                 (clk),
    .rst                 (rst),
    .action_in           (action_in),
    .action_valid        (action_valid),
    .action_ready        (action_ready),
    .operand_1_in        (operand_1_in),
    .operand_2_in        (operand_2_in),
    .container_out       (container_out),
    .container_out_valid (container_out_valid),
    .container_out_ready (container_out_ready),
    .overflow_out        (overflow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          ovf;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    action_in    = {op, 21'h15A5A};
    operand_1_in = a;
    operand_2_in = b;
  endtask

  function automatic logic [DW-1:0] stall_a(input int i);
    return DW'(48'h100 * (i + 1));
  endfunction

  function automatic logic [DW-1:0] stall_exp(input int i);
    return DW'(48'h100 * (i + 1) + (i + 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  sent, rcv, stalls_left, stalled_cycles;
  logic fire_in, fire_out;

  initial begin
    vecs[0]  = '{4'b0001, 48'hFFFF_FFFF_FFFF, 48'd2,     48'd1,               1'b1};
    vecs[1]  = '{4'b1001, 48'hFFFF_FFFF_FFFF, 48'd2,     48'hFFFF_FFFF_FFFF,  1'b1};
    vecs[2]  = '{4'b1010, 48'd5,              48'd9,     48'd0,               1'b1};
    vecs[3]  = '{4'b0101, 48'hF0,             48'h0C,    48'hFC,              1'b0};
    vecs[4]  = '{4'b0111, 48'hF0,             48'h0C,    48'hFC,              1'b0};
    vecs[5]  = '{4'b1011, 48'hF0,             48'h0C,    48'hF_0000,          1'b0};
    vecs[6]  = '{4'b1100, 48'hF0,             48'h0C,    48'h0,               1'b0};
    vecs[7]  = '{4'b0110, 48'd7,              48'd7,     48'd1,               1'b0};
    vecs[8]  = '{4'b1011, 48'd1,              48'd48,    48'd0,               1'b0};
    vecs[9]  = '{4'b0000, 48'h1234,           48'd5,     48'h1234,            1'b0};
    vecs[10] = '{4'b0010, 48'd3,              48'd5,     48'hFFFF_FFFF_FFFE,  1'b1};
    vecs[11] = '{4'b1000, 48'd9,              48'd9,     48'd1,               1'b0};
    vecs[12] = '{4'b0100, 48'hF0,             48'h0C,    48'h0,               1'b0};
    vecs[13] = '{4'b1110, 48'hAB,             48'hCD,    48'hCD,              1'b0};
    vecs[14] = '{4'b0110, 48'd3,              48'd7,     48'd0,               1'b0};
    vecs[15] = '{4'b1100, 48'hAB,             48'h40,    48'hAB,              1'b0};
    vecs[16] = '{4'b1001, 48'd1,              48'd2,     48'd3,               1'b0};
    vecs[17] = '{4'b1010, 48'd9,              48'd5,     48'd4,               1'b0};
    vecs[18] = '{4'b0001, 48'd2,              48'd3,     48'd5,               1'b0};
    vecs[19] = '{4'b1100, 48'h8000_0000_0000, 48'd47,    48'd1,               1'b0};
    vecs[20] = '{4'b1011, 48'd1,              48'h3F,    48'd0,               1'b0};
    vecs[21] = '{4'b1111, 48'h55,             48'h66,    48'h55,              1'b0};

    rst = 1'b1;
    action_valid = 1'b0;
    container_out_ready = 1'b1;
    drive(4'b0000, '0, '0);
    tick();
    tick();
    check("reset_valid", 64'(container_out_valid), 64'd0);
    check("reset_data",  64'(container_out), 64'd0);
    check("reset_ovf",   64'(overflow_out), 64'd0);
    rst = 1'b0;
    check("reset_ready", 64'(action_ready), 64'd1);

    // Back-to-back stream: vector k accepted at edge k+1, visible after edge k+3.
    action_valid = 1'b1;
    drive(vecs[0].op, vecs[0].a, vecs[0].b);
    for (int m = 1; m <= NV + 2; m++) begin
      tick();
      if (m < 3) begin
        check("latency_not_early", 64'(container_out_valid), 64'd0);
      end else begin
        check($sformatf("vec%0d_valid", m - 3), 64'(container_out_valid), 64'd1);
        check($sformatf("vec%0d_data", m - 3),  64'(container_out), 64'(vecs[m-3].res));
        check($sformatf("vec%0d_ovf", m - 3),   64'(overflow_out), 64'(vecs[m-3].ovf));
      end
      check("stream_ready", 64'(action_ready), 64'd1);
      if (m < NV) drive(vecs[m].op, vecs[m].a, vecs[m].b);
      else action_valid = 1'b0;
    end
    tick();
    check("bubble_valid", 64'(container_out_valid), 64'd0);
    check("bubble_hold",  64'(container_out), 64'(vecs[NV-1].res));
    tick();
    tick();

    // Six beats with a four-cycle downstream stall starting at the first result.
    sent = 0; rcv = 0; stalls_left = 4; stalled_cycles = 0;
    action_valid = 1'b1;
    drive(4'b0001, stall_a(0), DW'(1));
    for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
      @(negedge clk);
      if (container_out_valid) begin
        check($sformatf("stall_data%0d", rcv), 64'(container_out), 64'(stall_exp(rcv)));
        check("stall_ovf", 64'(overflow_out), 64'd0);
      end
      if (!container_out_ready) begin
        check("stall_ready_low", 64'(action_ready), 64'd0);
        stalled_cycles++;
      end
      fire_out = container_out_valid && container_out_ready;
      fire_in  = action_valid && action_ready;
      tick();
      if (fire_out) rcv++;
      if (fire_in) sent++;
      action_valid = (sent < 6);
      drive(4'b0001, stall_a(sent), DW'(sent + 1));
      if (container_out_valid && stalls_left > 0) begin
        container_out_ready = 1'b0;
        stalls_left--;
      end else begin
        container_out_ready = 1'b1;
      end
    end
    check("stall_received", 64'(rcv), 64'd6);
    check("stall_sent", 64'(sent), 64'd6);
    check("stall_cycles", 64'(stalled_cycles), 64'd4);
    container_out_ready = 1'b1;
    action_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_no_extra", 64'(container_out_valid), 64'd0);
    end

    // Reset with two beats in flight and a beat offered on the reset edge.
    action_valid = 1'b1;
    drive(4'b0001, 48'd1, 48'd1);
    tick();
    drive(4'b0001, 48'd2, 48'd2);
    tick();
    rst = 1'b1;
    drive(4'b0001, 48'd3, 48'd3);
    tick();
    rst = 1'b0;
    action_valid = 1'b0;
    check("rst_mid_valid", 64'(container_out_valid), 64'd0);
    check("rst_mid_data",  64'(container_out), 64'd0);
    check("rst_mid_ovf",   64'(overflow_out), 64'd0);
    check("rst_mid_ready", 64'(action_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_flush_valid", 64'(container_out_valid), 64'd0);
      check("rst_flush_data",  64'(container_out), 64'd0);
    end
    action_valid = 1'b1;
    drive(4'b0001, 48'd20, 48'd22);
    tick();
    action_valid = 1'b0;
    check("post_rst_lat1", 64'(container_out_valid), 64'd0);
    tick();
    check("post_rst_lat2", 64'(container_out_valid), 64'd0);
    tick();
    check("post_rst_valid", 64'(container_out_valid), 64'd1);
    check("post_rst_data",  64'(container_out), 64'd42);
    check("post_rst_ovf",   64'(overflow_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
